// File: rtl/inv_shift_rows_serial.sv
// rtl/inv_shift_rows_serial.sv - byte-serial AES InvShiftRows with ping-pong block buffers
// Optional INV_SHIFT_ROWS_FWD_EN adds a per-block fwd bit selecting forward ShiftRows.
module inv_shift_rows_serial (
  input  logic       clk,
  input  logic       rst,
`ifdef INV_SHIFT_ROWS_FWD_EN
  input  logic       fwd,
`endif
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last
);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} buf_state_e;

  buf_state_e  st_q [0:1];
  buf_state_e  st_d [0:1];
  logic [3:0]  wr_cnt_q, wr_cnt_d;
  logic [3:0]  rd_cnt_q, rd_cnt_d;
  logic        wr_sel_q, wr_sel_d;
  logic        rd_sel_q, rd_sel_d;
  logic [7:0]  mem_q [0:31];
  logic [7:0]  mem_d [0:31];
  logic        in_fire, out_fire;
  logic        blk_fwd;
  logic [1:0]  rd_row, rd_col, src_col;
  logic [4:0]  rd_slot;

`ifdef INV_SHIFT_ROWS_FWD_EN
  logic        fwd_q [0:1];
  logic        fwd_d [0:1];
  assign blk_fwd = fwd_q[rd_sel_q];
`else
  assign blk_fwd = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q[0]  <= EMPTY;
      st_q[1]  <= EMPTY;
      wr_cnt_q <= 4'd0;
      rd_cnt_q <= 4'd0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      st_q[0]  <= st_d[0];
      st_q[1]  <= st_d[1];
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
    end
  end

  // Block storage carries no reset; stale bytes are unreachable once states are EMPTY.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 32; i++) mem_q[i] <= mem_d[i];
`ifdef INV_SHIFT_ROWS_FWD_EN
    fwd_q[0] <= fwd_d[0];
    fwd_q[1] <= fwd_d[1];
`endif
  end

  // Output decode from registered state only
  always_comb begin
    in_ready  = (st_q[wr_sel_q] == EMPTY) || (st_q[wr_sel_q] == FILLING);
    out_valid = (st_q[rd_sel_q] == FULL) || (st_q[rd_sel_q] == DRAINING);
    rd_row    = rd_cnt_q[1:0];
    rd_col    = rd_cnt_q[3:2];
    src_col   = blk_fwd ? (rd_col + rd_row) : (rd_col - rd_row);
    rd_slot   = {rd_sel_q, src_col, rd_row};
    out_data  = out_valid ? mem_q[rd_slot] : 8'h00;
    out_last  = out_valid && (rd_cnt_q == 4'd15);
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Next-state logic; write and read never target the same buffer in one cycle.
  always_comb begin
    st_d[0]  = st_q[0];
    st_d[1]  = st_q[1];
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    for (int i = 0; i < 32; i++) mem_d[i] = mem_q[i];
`ifdef INV_SHIFT_ROWS_FWD_EN
    fwd_d[0] = fwd_q[0];
    fwd_d[1] = fwd_q[1];
`endif
    if (in_fire) begin
      mem_d[{wr_sel_q, wr_cnt_q}] = in_data;
`ifdef INV_SHIFT_ROWS_FWD_EN
      if (wr_cnt_q == 4'd0) fwd_d[wr_sel_q] = fwd;
`endif
      wr_cnt_d = wr_cnt_q + 4'd1;
      if (wr_cnt_q == 4'd15) begin
        st_d[wr_sel_q] = FULL;
        wr_sel_d       = ~wr_sel_q;
      end else begin
        st_d[wr_sel_q] = FILLING;
      end
    end
    if (out_fire) begin
      rd_cnt_d = rd_cnt_q + 4'd1;
      if (rd_cnt_q == 4'd15) begin
        st_d[rd_sel_q] = EMPTY;
        rd_sel_d       = ~rd_sel_q;
      end else begin
        st_d[rd_sel_q] = DRAINING;
      end
    end
  end

endmodule

// File: tb/tb_inv_shift_rows_serial.sv
// tb/tb_inv_shift_rows_serial.sv - directed and randomized-handshake checks for inv_shift_rows_serial
module tb_inv_shift_rows_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       fwd;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  inv_shift_rows_serial dut (
    .clk       (clk),
    .rst       (rst),
`ifdef INV_SHIFT_ROWS_FWD_EN
    .fwd       (fwd),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Output byte k takes input slot inv_tbl[k] (resp. fwd_tbl[k]), worked out by hand.
  logic [7:0] inv_tbl [16] = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                               8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
  logic [7:0] fwd_tbl [16] = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                               8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] src_q[$];
  logic       fwd_q[$];
  logic [7:0] exp_q[$];
  logic       lst_q[$];

  int tcyc, first_out, first_fire, last_fire, last_in, rdy_drops, hold_err, zero_err, n_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    first_out = -1; first_fire = -1; last_fire = -1; last_in = -1;
    rdy_drops = 0; hold_err = 0; zero_err = 0; n_out = 0;
  endtask

  task automatic push_block(input logic [7:0] b [16], input logic f);
    for (int k = 0; k < 16; k++) begin
      src_q.push_back(b[k]);
      fwd_q.push_back(f);
      exp_q.push_back(f ? b[fwd_tbl[k]] : b[inv_tbl[k]]);
      lst_q.push_back(k == 15);
    end
  endtask

  task automatic push_pat(input logic [7:0] base, input logic f);
    logic [7:0] b [16];
    for (int k = 0; k < 16; k++) b[k] = base + 8'(k);
    push_block(b, f);
  endtask

  task automatic clear_queues();
    src_q.delete(); fwd_q.delete(); exp_q.delete(); lst_q.delete();
  endtask

  // One iteration per clock, driven and sampled 1 time unit after the rising edge.
  task automatic stream(input int vp, input int rp, input int budget, input int max_out);
    logic       prev_hold;
    logic [7:0] prev_d;
    logic       prev_l;
    logic       in_fire, out_fire;
    prev_hold = 1'b0; prev_d = 8'h00; prev_l = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (src_q.size() == 0 && exp_q.size() == 0) break;
      if (max_out > 0 && n_out >= max_out) break;
      in_valid  = (src_q.size() > 0) && ($urandom_range(99) < vp);
      in_data   = in_valid ? src_q[0] : 8'h00;
      fwd       = in_valid ? fwd_q[0] : 1'b0;
      out_ready = ($urandom_range(99) < rp);
      if (prev_hold && (out_data !== prev_d || out_last !== prev_l)) hold_err++;
      if (!out_valid && (out_data !== 8'h00 || out_last !== 1'b0)) zero_err++;
      if (src_q.size() > 0 && !in_ready) rdy_drops++;
      if (out_valid && first_out < 0) first_out = tcyc;
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire) begin
        if (exp_q.size() == 0) begin
          check("extra_output", 1, 0);
        end else begin
          check($sformatf("data[%0d]", n_out), out_data, exp_q[0]);
          check($sformatf("last[%0d]", n_out), out_last, lst_q[0]);
          void'(exp_q.pop_front());
          void'(lst_q.pop_front());
        end
        if (first_fire < 0) first_fire = tcyc;
        last_fire = tcyc;
        n_out++;
      end
      if (in_fire) begin
        last_in = tcyc;
        void'(src_q.pop_front());
        void'(fwd_q.pop_front());
      end
      prev_hold = out_valid && !out_ready;
      prev_d = out_data;
      prev_l = out_last;
      @(posedge clk);
      #1;
      tcyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_last"}, out_last, 0);
  endtask

  initial begin
    logic [7:0] rb [16];
    rst = 1'b1; fwd = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; tcyc = 0;
    repeat (3) @(posedge clk);
    #1;
    do_reset("reset");

    // Single block, latency from last input byte
    clear_stats(); clear_queues();
    push_pat(8'h00, 1'b0);
    stream(100, 100, 100, 0);
    check("t1_drain", exp_q.size(), 0);
    check("t1_latency", first_out - last_in, 1);
    check("t1_zero_when_idle", zero_err, 0);

    // Four back-to-back blocks at full rate
    clear_stats(); clear_queues();
    for (int b = 0; b < 4; b++) push_pat(8'(16 * b), 1'b0);
    stream(100, 100, 200, 0);
    check("t2_drain", exp_q.size(), 0);
    check("t2_in_ready_drops", rdy_drops, 0);
    check("t2_out_span", last_fire - first_fire, 63);

    // Backpressure: both buffers fill, output held
    clear_stats(); clear_queues();
    for (int b = 0; b < 3; b++) push_pat(8'(16 * b), 1'b0);
    stream(100, 0, 40, 0);
    check("t3_accepted", 48 - src_q.size(), 32);
    check("t3_in_ready", in_ready, 0);
    check("t3_out_valid", out_valid, 1);
    check("t3_out_data", out_data, 8'h00);
    check("t3_hold", hold_err, 0);
    stream(100, 100, 200, 0);
    check("t3_drain", exp_q.size(), 0);

    // Reset mid-fill and mid-drain
    clear_stats(); clear_queues();
    for (int k = 0; k < 7; k++) begin
      src_q.push_back(8'h40 + 8'(k)); fwd_q.push_back(1'b0);
    end
    stream(100, 0, 20, 0);
    do_reset("t4_rst_fill");
    clear_stats(); clear_queues();
    push_pat(8'h50, 1'b0);
    stream(100, 100, 100, 5);
    check("t4_mid_valid", out_valid, 1);
    do_reset("t4_rst_drain");
    clear_stats(); clear_queues();
    push_pat(8'h10, 1'b0);
    stream(100, 100, 100, 0);
    check("t4_drain", exp_q.size(), 0);
    check("t4_count", n_out, 16);

    // Random handshakes over 200 random blocks
    clear_stats(); clear_queues();
    for (int b = 0; b < 200; b++) begin
      for (int k = 0; k < 16; k++) rb[k] = 8'($urandom_range(255));
      push_block(rb, 1'b0);
    end
    stream(50, 50, 20000, 0);
    check("t5_drain", exp_q.size(), 0);
    check("t5_hold", hold_err, 0);
    check("t5_zero_when_idle", zero_err, 0);

`ifdef INV_SHIFT_ROWS_FWD_EN
    clear_stats(); clear_queues();
    push_pat(8'h00, 1'b1);
    push_pat(8'h00, 1'b0);
    stream(100, 100, 200, 0);
    check("t6_drain", exp_q.size(), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
